// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and load/store,
// serialising word/halfword/byte accesses into per-byte RAM cycles (little-endian).
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] IF_LEN = CW'(4);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        LS_RD,
        LS_WR
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] len, len_n;
    logic [AW-1:0] base, base_n;
    logic [31:0]   wdata, wdata_n;
    logic [31:0]   rbuf, rbuf_n;
    logic [1:0]    cap_idx;
    logic          if_done_n, ls_done_n;
    logic [31:0]   if_inst_n, ls_rdata_n;
    logic [AW-1:0] ram_a_n;
    logic          wr_q, wr_n;
    logic [DW-1:0] ram_dout_n;

    function automatic logic [CW-1:0] decode_len(input logic [2:0] l);
        if (l[2])      return CW'(4);
        else if (l[1]) return CW'(2);
        else           return CW'(1);
    endfunction

    // Byte arriving now belongs to the address driven one cycle earlier.
    assign cap_idx = cnt[1:0] - 2'd1;

    // A write in flight is dropped the moment reset is seen.
    assign ram_wr = wr_q & ~rst;

    // Next-state, byte sequencing and the next values of the registered outputs
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        len_n      = len;
        base_n     = base;
        wdata_n    = wdata;
        rbuf_n     = rbuf;
        if_done_n  = 1'b0;
        ls_done_n  = 1'b0;
        if_inst_n  = if_inst;
        ls_rdata_n = ls_rdata;
        ram_a_n    = '0;
        wr_n       = 1'b0;
        ram_dout_n = '0;

        case (state)
            IDLE: begin
                // A requester whose done is high this cycle is still holding its old req.
                if (ls_req && !ls_done) begin
                    state_n = ls_we ? LS_WR : LS_RD;
                    cnt_n   = '0;
                    len_n   = decode_len(ls_len);
                    base_n  = ls_addr;
                    wdata_n = ls_wdata;
                    rbuf_n  = '0;
                end else if (if_req && !if_cancel && !if_done) begin
                    state_n = IF_RD;
                    cnt_n   = '0;
                    len_n   = IF_LEN;
                    base_n  = if_addr;
                    rbuf_n  = '0;
                end
            end
            IF_RD, LS_RD: begin
                if (state == IF_RD && if_cancel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    if (cnt != '0) begin
                        rbuf_n[{cap_idx, 3'b000} +: DW] = ram_din;
                    end
                    if (cnt == len) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        if (state == IF_RD) begin
                            if_done_n = 1'b1;
                            if_inst_n = rbuf_n;
                        end else begin
                            ls_done_n  = 1'b1;
                            ls_rdata_n = rbuf_n;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            LS_WR: begin
                if (cnt == len - CW'(1)) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    ls_done_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // RAM port is registered, so it is driven from the state being entered.
        if ((state_n == IF_RD || state_n == LS_RD) && cnt_n < len_n) begin
            ram_a_n = base_n + AW'(cnt_n);
        end else if (state_n == LS_WR) begin
            ram_a_n    = base_n + AW'(cnt_n);
            wr_n       = 1'b1;
            ram_dout_n = wdata_n[{cnt_n[1:0], 3'b000} +: DW];
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            len      <= '0;
            base     <= '0;
            wdata    <= '0;
            rbuf     <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_inst  <= '0;
            ls_rdata <= '0;
            ram_a    <= '0;
            wr_q     <= 1'b0;
            ram_dout <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            len      <= len_n;
            base     <= base_n;
            wdata    <= wdata_n;
            rbuf     <= rbuf_n;
            if_done  <= if_done_n;
            ls_done  <= ls_done_n;
            if_inst  <= if_inst_n;
            ls_rdata <= ls_rdata_n;
            ram_a    <= ram_a_n;
            wr_q     <= wr_n;
            ram_dout <= ram_dout_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, if_done;
    logic [31:0] if_addr, if_inst;
    logic        ls_req, ls_we, ls_done;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [2:0]  ls_len;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout, ram_din;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_done(if_done), .if_inst(if_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_len(ls_len),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Environment RAM and the reference model's own copy of memory
    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a]     = d;
        ref_mem[a] = d;
    endtask

    always @(posedge clk) begin
        ram_din <= ram_rd(ram_a);
        if (ram_wr) ram[ram_a] = ram_dout;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
        end
    endtask

    // Reference model: one transaction at a time, expected outputs for the next cycle
    logic [31:0] m_a = '0, m_inst = '0, m_rdata = '0;
    logic        m_wr = 1'b0, m_ifd = 1'b0, m_lsd = 1'b0;
    logic [7:0]  m_dout = '0;
    bit          act = 1'b0, kif = 1'b0, kwr = 1'b0;
    int          t0 = 0, tdone = 0, n = 0;
    logic [31:0] mbase = '0, mdata = '0;

    always @(posedge clk) begin
        int k;
        k = cyc - t0;
        if (act && kwr && k >= 1 && k <= n && !rst)
            ref_mem[mbase + 32'(k - 1)] = mdata[8*(k-1) +: 8];
        if (rst) begin
            act = 1'b0;
            m_a = '0; m_wr = 1'b0; m_dout = '0; m_ifd = 1'b0; m_lsd = 1'b0;
            m_inst = '0; m_rdata = '0;
        end else begin
            if (act && cyc >= tdone) act = 1'b0;
            if (act && kif && if_cancel) act = 1'b0;
            if (!act && ls_req && !m_lsd) begin
                act = 1'b1; kif = 1'b0; kwr = ls_we; t0 = cyc; mbase = ls_addr;
                n = ls_len[2] ? 4 : (ls_len[1] ? 2 : 1);
                if (ls_we) begin
                    mdata = ls_wdata;
                    tdone = t0 + n + 1;
                end else begin
                    mdata = '0;
                    for (int i = 0; i < n; i++) mdata[8*i +: 8] = ref_rd(mbase + 32'(i));
                    tdone = t0 + n + 2;
                end
            end else if (!act && if_req && !if_cancel && !m_ifd) begin
                act = 1'b1; kif = 1'b1; kwr = 1'b0; t0 = cyc; mbase = if_addr; n = 4;
                mdata = '0;
                for (int i = 0; i < 4; i++) mdata[8*i +: 8] = ref_rd(mbase + 32'(i));
                tdone = t0 + 6;
            end
            k = cyc + 1 - t0;
            m_a = '0; m_wr = 1'b0; m_dout = '0; m_ifd = 1'b0; m_lsd = 1'b0;
            if (act) begin
                if (k >= 1 && k <= n) begin
                    m_a = mbase + 32'(k - 1);
                    if (kwr) begin
                        m_wr   = 1'b1;
                        m_dout = mdata[8*(k-1) +: 8];
                    end
                end
                if (cyc + 1 == tdone) begin
                    if (kif) begin
                        m_ifd  = 1'b1;
                        m_inst = mdata;
                    end else begin
                        m_lsd = 1'b1;
                        if (!kwr) m_rdata = mdata;
                    end
                end
            end
        end
        cyc++;
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("ram_a",    ram_a,             m_a);
            check("ram_wr",   32'(ram_wr),       32'(m_wr && !rst));
            check("ram_dout", 32'(ram_dout),     32'(m_dout));
            check("if_done",  32'(if_done),      32'(m_ifd));
            check("ls_done",  32'(ls_done),      32'(m_lsd));
            check("if_inst",  if_inst,           m_inst);
            check("ls_rdata", ls_rdata,          m_rdata);
        end
    end

    task automatic wait_done(input bit is_if, input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (is_if ? if_done : ls_done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL timeout waiting for %s done after %0d cycles", is_if ? "if" : "ls", budget);
        end
    endtask

    task automatic ls_start(input bit we, input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
        ls_req = 1'b1; ls_we = we; ls_addr = a; ls_len = l; ls_wdata = d;
    endtask

    initial begin
        int lat, seen;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_cancel = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
        poke(32'h200, 8'h93); poke(32'h201, 8'h00); poke(32'h202, 8'h10); poke(32'h203, 8'h00);
        for (int i = 0; i < 4; i++) poke(32'h3000 + 32'(i), 8'hAA);
        poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);

        repeat (3) @(negedge clk);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_ram_a",   ram_a,   32'h0);
        check("rst_done",    32'({if_done, ls_done, ram_wr}), 32'h0);
        rst = 1'b0;

        // Instruction fetch
        if_req = 1'b1; if_addr = 32'h100;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i <= 4) check("fetch_addr", ram_a, 32'h100 + 32'(i - 1));
            check("fetch_nowr", 32'(ram_wr), 32'h0);
            if (if_done) begin
                lat = i;
                break;
            end
        end
        check("fetch_lat",  32'(lat), 32'd6);
        check("fetch_inst", if_inst,  32'h00A00513);
        if_req = 1'b0;

        // Store word, then byte and halfword loads
        @(negedge clk);
        ls_start(1'b1, 32'h2000, 3'd4, 32'hDEADBEEF);
        wait_done(1'b0, 12, lat);
        ls_req = 1'b0;
        check("store_lat", 32'(lat), 32'd5);
        check("store_mem", {ram_rd(32'h2003), ram_rd(32'h2002), ram_rd(32'h2001), ram_rd(32'h2000)}, 32'hDEADBEEF);
        @(negedge clk);
        ls_start(1'b0, 32'h2002, 3'd1, 32'h0);
        wait_done(1'b0, 12, lat);
        ls_req = 1'b0;
        check("ldb_lat",  32'(lat), 32'd3);
        check("ldb_data", ls_rdata, 32'h000000AD);
        @(negedge clk);
        ls_start(1'b0, 32'h2000, 3'b010, 32'h0);
        wait_done(1'b0, 12, lat);
        ls_req = 1'b0;
        check("ldh_lat",  32'(lat), 32'd4);
        check("ldh_data", ls_rdata, 32'h0000BEEF);

        // Contention: LS wins, IF accepted in the ls_done cycle
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        ls_start(1'b0, 32'h2000, 3'b110, 32'h0);
        wait_done(1'b0, 12, lat);
        ls_req = 1'b0;
        check("cont_ls_lat",  32'(lat), 32'd6);
        check("cont_ls_data", ls_rdata, 32'hDEADBEEF);
        wait_done(1'b1, 12, lat);
        if_req = 1'b0;
        check("cont_if_lat",  32'(lat), 32'd6);
        check("cont_if_inst", if_inst,  32'h00A00513);

        // Cancel in T3 of a fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        if_cancel = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("cancel_idle", ram_a, 32'h0);
        if_cancel = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_done) seen++;
        end
        check("cancel_nodone", 32'(seen), 32'd0);
        if_req = 1'b1; if_addr = 32'h200;
        wait_done(1'b1, 12, lat);
        if_req = 1'b0;
        check("refetch_lat",  32'(lat), 32'd6);
        check("refetch_inst", if_inst,  32'h00100093);

        // Reset in T2 of a word store
        @(negedge clk);
        ls_start(1'b1, 32'h3000, 3'd4, 32'h11223344);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_ram", {ram_a[23:0], ram_dout}, 32'h0);
        check("rstmid_out", 32'({ram_wr, if_done, ls_done}), 32'h0);
        check("rstmid_res", if_inst | ls_rdata, 32'h0);
        rst = 1'b0; ls_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ls_done) seen++;
        end
        check("rstmid_nodone", 32'(seen), 32'd0);
        check("rstmid_mem", {ram_rd(32'h3003), ram_rd(32'h3002), ram_rd(32'h3001), ram_rd(32'h3000)}, 32'hAAAAAA44);

        // Address wrap on a halfword load
        ls_start(1'b0, 32'hFFFF_FFFF, 3'b010, 32'h0);
        @(negedge clk);
        check("wrap_a0", ram_a, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_a1", ram_a, 32'h0000_0000);
        wait_done(1'b0, 12, lat);
        ls_req = 1'b0;
        check("wrap_lat",  32'(lat), 32'd2);
        check("wrap_data", ls_rdata, 32'h00001234);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
